// File: rtl/uart_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_rx
// Purpose  : UART receiver with packet deframer [HDR][PAYLOAD x N][CKSUM].
//            Optional macro UART_PKT_RX_PARITY_EN adds an even-parity bit.
// Revision : 1.0
// ============================================================================
module uart_pkt_rx #(
    parameter int                   CLKS_PER_BIT  = 16,
    parameter int                   DATA_BITS     = 8,
    parameter int                   PAYLOAD_BYTES = 3,
    parameter logic [DATA_BITS-1:0] HDR_VALUE     = 8'hA5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               received_data,
    output logic                               DataRdy,
    output logic [DATA_BITS-1:0]               Header,
    output logic [PAYLOAD_BYTES*DATA_BITS-1:0] ImageData,
    output logic [DATA_BITS-1:0]               CheckSum,
    output logic                               Strb,
    output logic                               frame_err,
    output logic                               cksum_err
);

    localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w  = $clog2(DATA_BITS);
    localparam int c_pcnt_w = $clog2(PAYLOAD_BYTES + 1);
    localparam int c_pay_w  = PAYLOAD_BYTES * DATA_BITS;
    localparam logic [c_cnt_w-1:0]  c_cnt_full = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_pcnt_w-1:0] c_pay_last = c_pcnt_w'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        CS_IDLE      = 3'd0,
        CS_START     = 3'd1,
        CS_DATA      = 3'd2,
`ifdef UART_PKT_RX_PARITY_EN
        CS_PARITY    = 3'd3,
`endif
        CS_STOP      = 3'd4,
        CS_WAIT_HIGH = 3'd5
    } char_state_t;

    typedef enum logic [1:0] {
        PS_WAIT_HDR = 2'd0,
        PS_PAYLOAD  = 2'd1,
        PS_CKSUM    = 2'd2
    } pkt_state_t;

    char_state_t          r_char_state, w_char_next;
    pkt_state_t           r_pkt_state, w_pkt_next;
    logic                 r_rx_meta, r_rx_sync;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bit_w-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift, r_rx_data, r_sum, r_header, r_cksum;
    logic [c_pay_w-1:0]   r_stage, r_image, w_stage_shift;
    logic [c_pcnt_w-1:0]  r_pcnt;
    logic                 r_data_rdy, r_frame_err, r_strb, r_cksum_err;
    logic                 w_tick, w_half, w_stop_ok;
`ifdef UART_PKT_RX_PARITY_EN
    logic                 r_par_ok;
`endif

    // ---------------- character FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_char_state <= CS_IDLE;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_char_state <= w_char_next;
        end
    end

    always_comb begin
        w_char_next = r_char_state;
        w_tick      = (r_cnt == c_cnt_full);
        w_half      = (r_cnt == c_cnt_half);
`ifdef UART_PKT_RX_PARITY_EN
        w_stop_ok   = r_rx_sync && r_par_ok;
`else
        w_stop_ok   = r_rx_sync;
`endif
        case (r_char_state)
            CS_IDLE:      if (!r_rx_sync) w_char_next = CS_START;
            CS_START:     if (w_half) w_char_next = r_rx_sync ? CS_IDLE : CS_DATA;
            CS_DATA: begin
                if (w_tick && (r_bit_idx == c_bit_last)) begin
`ifdef UART_PKT_RX_PARITY_EN
                    w_char_next = CS_PARITY;
`else
                    w_char_next = CS_STOP;
`endif
                end
            end
`ifdef UART_PKT_RX_PARITY_EN
            CS_PARITY:    if (w_tick) w_char_next = CS_STOP;
`endif
            // A low stop bit must see the line return high before re-arming.
            CS_STOP:      if (w_tick) w_char_next = r_rx_sync ? CS_IDLE : CS_WAIT_HIGH;
            CS_WAIT_HIGH: if (r_rx_sync) w_char_next = CS_IDLE;
            default:      w_char_next = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_data_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_PKT_RX_PARITY_EN
            r_par_ok    <= 1'b1;
`endif
        end else begin
            r_data_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_char_state)
                CS_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                CS_DATA: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_PKT_RX_PARITY_EN
                CS_PARITY: begin
                    if (w_tick) begin
                        r_cnt    <= '0;
                        r_par_ok <= ~((^r_shift) ^ r_rx_sync);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                CS_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_stop_ok) begin
                            r_rx_data  <= r_shift;
                            r_data_rdy <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    // ---------------- packet FSM ----------------
    generate
        if (PAYLOAD_BYTES == 1) begin : g_stage_single
            assign w_stage_shift = r_rx_data;
        end else begin : g_stage_multi
            assign w_stage_shift = {r_stage[c_pay_w-DATA_BITS-1:0], r_rx_data};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_pkt_state <= PS_WAIT_HDR;
        else     r_pkt_state <= w_pkt_next;
    end

    always_comb begin
        w_pkt_next = r_pkt_state;
        if (r_frame_err) begin
            w_pkt_next = PS_WAIT_HDR;
        end else if (r_data_rdy) begin
            case (r_pkt_state)
                PS_WAIT_HDR: if (r_rx_data == HDR_VALUE) w_pkt_next = PS_PAYLOAD;
                PS_PAYLOAD:  if (r_pcnt == c_pay_last) w_pkt_next = PS_CKSUM;
                default:     w_pkt_next = PS_WAIT_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_pcnt      <= '0;
            r_stage     <= '0;
            r_header    <= '0;
            r_image     <= '0;
            r_cksum     <= '0;
            r_strb      <= 1'b0;
            r_cksum_err <= 1'b0;
        end else begin
            r_strb      <= 1'b0;
            r_cksum_err <= 1'b0;
            if (r_data_rdy) begin
                case (r_pkt_state)
                    PS_WAIT_HDR: begin
                        r_sum  <= HDR_VALUE;
                        r_pcnt <= '0;
                    end
                    PS_PAYLOAD: begin
                        r_stage <= w_stage_shift;
                        r_sum   <= r_sum + r_rx_data;
                        r_pcnt  <= r_pcnt + 1'b1;
                    end
                    default: begin
                        if (r_rx_data == r_sum) begin
                            r_header <= HDR_VALUE;
                            r_image  <= r_stage;
                            r_cksum  <= r_rx_data;
                            r_strb   <= 1'b1;
                        end else begin
                            r_cksum_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign received_data = r_rx_data;
    assign DataRdy       = r_data_rdy;
    assign Header        = r_header;
    assign ImageData     = r_image;
    assign CheckSum      = r_cksum;
    assign Strb          = r_strb;
    assign frame_err     = r_frame_err;
    assign cksum_err     = r_cksum_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_pkt_rx
// Purpose  : Directed self-checking bench for uart_pkt_rx (default parameters).
// Revision : 1.0
// ============================================================================
module tb_uart_pkt_rx;

    localparam int CPB = 16;
    localparam int TIMEOUT_NS = 2000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  received_data, Header, CheckSum;
    logic [23:0] ImageData;
    logic        DataRdy, Strb, frame_err, cksum_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rdy = 0, n_strb = 0, n_ferr = 0, n_cerr = 0, n_excl = 0;
    int b_rdy, b_strb, b_ferr, b_cerr;

    uart_pkt_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PAYLOAD_BYTES(3),
        .HDR_VALUE    (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .received_data(received_data),
        .DataRdy      (DataRdy),
        .Header       (Header),
        .ImageData    (ImageData),
        .CheckSum     (CheckSum),
        .Strb         (Strb),
        .frame_err    (frame_err),
        .cksum_err    (cksum_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (DataRdy)   n_rdy++;
        if (Strb)      n_strb++;
        if (frame_err) n_ferr++;
        if (cksum_err) n_cerr++;
        if ((int'(Strb) + int'(frame_err) + int'(cksum_err)) > 1) n_excl++;
    end

    initial begin
        #(TIMEOUT_NS);
        n_bad++;
        $error("FAIL timeout: simulation did not finish within %0d ns", TIMEOUT_NS);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] c, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
`ifdef UART_PKT_RX_PARITY_EN
        send_bit((^c) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        send_bit(stop);
        if (!stop) send_bit(1'b1);
    endtask

    task automatic send_pkt(input logic [39:0] p);
        for (int i = 4; i >= 0; i--) send_char(p[i*8 +: 8], 1'b1, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic mark;
        b_rdy  = n_rdy;
        b_strb = n_strb;
        b_ferr = n_ferr;
        b_cerr = n_cerr;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_data",   received_data, 8'h00);
        check("rst_rdy",    DataRdy,       1'b0);
        check("rst_hdr",    Header,        8'h00);
        check("rst_img",    ImageData,     24'h0);
        check("rst_ck",     CheckSum,      8'h00);
        check("rst_strb",   Strb,          1'b0);
        check("rst_ferr",   frame_err,     1'b0);
        check("rst_cerr",   cksum_err,     1'b0);

        // 1: good packet
        mark();
        send_pkt(40'hA5_11_22_33_0B);
        check("t1_rdy",   n_rdy - b_rdy,   5);
        check("t1_strb",  n_strb - b_strb, 1);
        check("t1_cerr",  n_cerr - b_cerr, 0);
        check("t1_hdr",   Header,          8'hA5);
        check("t1_img",   ImageData,       24'h112233);
        check("t1_ck",    CheckSum,        8'h0B);
        check("t1_last",  received_data,   8'h0B);

        // 2: bad checksum then a good packet
        mark();
        send_pkt(40'hA5_11_22_33_0C);
        check("t2_cerr",  n_cerr - b_cerr, 1);
        check("t2_strb",  n_strb - b_strb, 0);
        check("t2_img",   ImageData,       24'h112233);
        check("t2_ck",    CheckSum,        8'h0B);
        mark();
        send_pkt(40'hA5_44_55_66_A4);
        check("t2b_strb", n_strb - b_strb, 1);
        check("t2b_img",  ImageData,       24'h445566);
        check("t2b_ck",   CheckSum,        8'hA4);

        // 3: junk before header, header value inside payload
        mark();
        send_char(8'h00, 1'b1, 1'b0);
        send_char(8'h7E, 1'b1, 1'b0);
        send_pkt(40'hA5_A5_01_02_4D);
        check("t3_rdy",   n_rdy - b_rdy,   7);
        check("t3_strb",  n_strb - b_strb, 1);
        check("t3_img",   ImageData,       24'hA50102);
        check("t3_ck",    CheckSum,        8'h4D);

        // 4: start-bit glitch, then framing error mid-packet
        mark();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_g_rdy",  n_rdy - b_rdy,   0);
        check("t4_g_ferr", n_ferr - b_ferr, 0);
        mark();
        send_char(8'hA5, 1'b1, 1'b0);
        send_char(8'h11, 1'b1, 1'b0);
        send_char(8'h22, 1'b0, 1'b0);
        check("t4_ferr",  n_ferr - b_ferr, 1);
        check("t4_rdy",   n_rdy - b_rdy,   2);
        send_pkt(40'hA5_11_22_33_0B);
        check("t4_strb",  n_strb - b_strb, 1);
        check("t4_img",   ImageData,       24'h112233);
        check("t4_excl",  n_excl,          0);

        // 5: reset mid-payload
        send_char(8'hA5, 1'b1, 1'b0);
        send_char(8'h11, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_data",  received_data, 8'h00);
        check("t5_hdr",   Header,        8'h00);
        check("t5_img",   ImageData,     24'h0);
        check("t5_ck",    CheckSum,      8'h00);
        check("t5_strb",  Strb,          1'b0);
        mark();
        repeat (20) @(negedge clk);
        send_char(8'h33, 1'b1, 1'b0);
        send_char(8'h0B, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("t5_nostrb", n_strb - b_strb, 0);
        check("t5_hdr2",   Header,          8'h00);
        send_pkt(40'hA5_11_22_33_0B);
        check("t5_strb2",  n_strb - b_strb, 1);
        check("t5_img2",   ImageData,       24'h112233);
        check("t5_hdr3",   Header,          8'hA5);

`ifdef UART_PKT_RX_PARITY_EN
        // 6: parity
        mark();
        send_char(8'h11, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_ferr",  n_ferr - b_ferr, 1);
        check("t6_rdy0",  n_rdy - b_rdy,   0);
        mark();
        send_char(8'h11, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_rdy1",  n_rdy - b_rdy,   1);
        check("t6_data",  received_data,   8'h11);
        check("t6_ferr0", n_ferr - b_ferr, 0);
`endif

        check("excl_all", n_excl, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
